// File: rtl/load_down_timer.sv
// load_down_timer: loadable down-counting "wait N cycles" timer.
// A load of N produces exactly N cycles with tc low, after which tc stays
// high until the next load. Build option: define TIMER_COUNT_OUT_EN to add
// the count_out debug tap that mirrors the count register.
module load_down_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
`ifdef TIMER_COUNT_OUT_EN
  output logic [WIDTH-1:0] count_out,
`endif
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             count_zero;

  assign count_zero = (count_reg == '0);

  // Next count: load replaces the remaining count, otherwise decrement and
  // saturate at zero. data is only consulted under load so an unknown data
  // bus cannot leak into the count while idle.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = data;
    end else if (!count_zero) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Count register; reset takes priority over a simultaneous load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Terminal count is decoded straight from the register, no extra stage.
  assign tc = count_zero;

`ifdef TIMER_COUNT_OUT_EN
  assign count_out = count_reg;
`endif

endmodule

// File: tb/tb_load_down_timer.sv
// Self-checking bench for load_down_timer: directed scenarios with literal
// expectations plus randomized loads compared cycle-by-cycle to a model of
// "cycles remaining until terminal count".
module tb_load_down_timer;

  localparam int WIDTH = 10;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             tc;
`ifdef TIMER_COUNT_OUT_EN
  logic [WIDTH-1:0] count_out;
`endif

  int checks = 0;
  int errors = 0;

  // Model: number of remaining cycles with tc low.
  int remaining   = 0;
  bit model_valid = 0;

  load_down_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (data),
`ifdef TIMER_COUNT_OUT_EN
    .count_out(count_out),
`endif
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model updated at each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (reset) begin
      remaining   = 0;
      model_valid = 1;
    end else if (load) begin
      remaining   = int'(data);
      model_valid = 1;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (tc !== (remaining == 0)) begin
        errors++;
        $display("FAIL model_tc t=%0t tc=%b expected=%b remaining=%0d",
                 $time, tc, (remaining == 0), remaining);
      end
`ifdef TIMER_COUNT_OUT_EN
      checks++;
      if (count_out !== WIDTH'(remaining)) begin
        errors++;
        $display("FAIL model_count_out t=%0t count_out=%0d expected=%0d",
                 $time, count_out, remaining);
      end
`endif
    end
  end

  // Apply inputs, then advance to 1 time unit past the next rising edge.
  task automatic step(input bit r, input bit l, input logic [WIDTH-1:0] d);
    reset = r;
    load  = l;
    data  = d;
    @(posedge clk);
    #1;
    $display("step t=%0t reset=%b load=%b data=%h tc=%b", $time, r, l, d, tc);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 'x);
  endtask

  task automatic expect_tc(input logic exp, input string name);
    checks++;
    if (tc !== exp) begin
      errors++;
      $display("FAIL %s tc=%b expected=%b", name, tc, exp);
    end
  endtask

  task automatic expect_int(input int act, input int exp, input string name);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Count cycles with tc low until tc rises, bounded.
  task automatic count_low(output int n);
    n = 0;
    while (tc === 1'b0 && n < 2000) begin
      n++;
      idle();
    end
  endtask

  int n;

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    data  = '0;

    // Reset then idle: tc high and stays high.
    step(1'b1, 1'b0, 'x);
    expect_tc(1'b1, "reset_tc");
    expect_int(remaining, 0, "reset_model");
`ifdef TIMER_COUNT_OUT_EN
    checks++;
    if (count_out !== '0) begin
      errors++;
      $display("FAIL reset_count_out count_out=%0d expected=0", count_out);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      idle();
      expect_tc(1'b1, "reset_idle_tc");
    end

    // Load 3 at E: low after E, E+1, E+2; high after E+3 and holds.
    step(1'b0, 1'b1, WIDTH'(3));
    expect_tc(1'b0, "load3_E");
    expect_int(remaining, 3, "load3_model");
    idle(); expect_tc(1'b0, "load3_E1");
    idle(); expect_tc(1'b0, "load3_E2");
    idle(); expect_tc(1'b1, "load3_E3");
    idle(); expect_tc(1'b1, "load3_E4");

    // Load 0: tc high immediately.
    step(1'b0, 1'b1, '0);
    expect_tc(1'b1, "load0");

    // Load all-ones: exactly MAXV low cycles.
    step(1'b0, 1'b1, WIDTH'(MAXV));
    count_low(n);
    expect_int(n, 1023, "loadmax_low_cycles");
    idle(); expect_tc(1'b1, "loadmax_hold");

    // Reload mid-count: 16 then 10 -> 10 low cycles after the reload edge.
    step(1'b0, 1'b1, WIDTH'(16));
    step(1'b0, 1'b1, WIDTH'(10));
    count_low(n);
    expect_int(n, 10, "reload_low_cycles");

    // Reset wins over load on the 4th edge.
    step(1'b0, 1'b1, WIDTH'(10));
    idle();
    idle();
    expect_tc(1'b0, "abort_before");
    step(1'b1, 1'b1, WIDTH'(5));
    expect_tc(1'b1, "abort_reset_wins");
    idle(); expect_tc(1'b1, "abort_hold");

    // Randomized loads with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 63) == 0)
        step(1'b1, ($urandom_range(0, 1) == 1), WIDTH'($urandom_range(0, 32)));
      else if ($urandom_range(0, 15) == 0)
        step(1'b0, 1'b1, WIDTH'($urandom_range(0, 32)));
      else
        idle();
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
